// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: classifies writeback retire events, queues them in a small FIFO,
// drains them over valid/ready, and sequences halt (stop accepting, drain, then done).
module retire_trace_buffer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_pc,
    input  logic              ret_reg_wr,
    input  logic [REG_W-1:0]  ret_reg,
    input  logic [DATA_W-1:0] ret_reg_data,
    input  logic              ret_mem_rd,
    input  logic              ret_mem_wr,
    input  logic [ADDR_W-1:0] ret_mem_addr,
    input  logic [DATA_W-1:0] ret_mem_data,
    input  logic              ret_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [CNT_W-1:0]  out_inum,
    output logic [ADDR_W-1:0] out_pc,
    output logic [REG_W-1:0]  out_reg,
    output logic [DATA_W-1:0] out_reg_data,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic              overflow,
    output logic              halted,
    output logic              done
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [ADDR_W-1:0] pc;
        logic [REG_W-1:0]  regNum;
        logic [DATA_W-1:0] regData;
        logic [ADDR_W-1:0] memAddr;
        logic [DATA_W-1:0] memData;
    } rec_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state;
    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count;
    logic             full, empty, accept, push, pop;
    logic [2:0]       kind;
    rec_t             newRec, head;

    always_comb begin
        kind = 3'd0;
        if (ret_halt)                      kind = 3'd5;
        else if (ret_reg_wr && ret_mem_wr) kind = 3'd3;
        else if (ret_reg_wr && ret_mem_rd) kind = 3'd2;
        else if (ret_reg_wr)               kind = 3'd1;
        else if (ret_mem_wr)               kind = 3'd4;
    end

    assign empty  = (count == '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign accept = ret_valid && (state == RUN);
    assign pop    = !empty && out_ready;
    // A full FIFO can still take a record when the head leaves in the same cycle.
    assign push   = accept && (!full || pop);

    assign newRec = '{kind: kind, inum: inst_count, pc: ret_pc, regNum: ret_reg,
                      regData: ret_reg_data, memAddr: ret_mem_addr, memData: ret_mem_data};

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= newRec;
    end

    assign head         = mem[rdPtr];
    assign out_valid    = !empty;
    assign out_kind     = head.kind;
    assign out_inum     = head.inum;
    assign out_pc       = head.pc;
    assign out_reg      = head.regNum;
    assign out_reg_data = head.regData;
    assign out_mem_addr = head.memAddr;
    assign out_mem_data = head.memData;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
            done        <= 1'b0;
            state       <= RUN;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Dropped records still consume an instruction number, leaving a visible gap.
            if (accept) begin
                inst_count <= inst_count + 1'b1;
                if (!push) overflow <= 1'b1;
            end
            if (state == RUN) cycle_count <= cycle_count + 1'b1;
            case (state)
                RUN: if (accept && ret_halt) begin
                    state  <= DRAIN;
                    halted <= 1'b1;
                end
                DRAIN: if (empty) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios plus random traffic, all checked
// each cycle against a queue-based reference model of the trace buffer.
module tb_retire_trace_buffer;
    localparam int ADDR_W = 16, DATA_W = 16, REG_W = 3, DEPTH = 8, CNT_W = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic ret_valid = 1'b0, ret_reg_wr = 1'b0, ret_mem_rd = 1'b0, ret_mem_wr = 1'b0, ret_halt = 1'b0;
    logic [ADDR_W-1:0] ret_pc = '0, ret_mem_addr = '0;
    logic [REG_W-1:0]  ret_reg = '0;
    logic [DATA_W-1:0] ret_reg_data = '0, ret_mem_data = '0;
    logic out_ready = 1'b0;
    logic out_valid, overflow, halted, done;
    logic [2:0] out_kind;
    logic [CNT_W-1:0] out_inum, cycle_count, inst_count;
    logic [ADDR_W-1:0] out_pc, out_mem_addr;
    logic [REG_W-1:0] out_reg;
    logic [DATA_W-1:0] out_reg_data, out_mem_data;

    retire_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_reg_wr(ret_reg_wr),
        .ret_reg(ret_reg), .ret_reg_data(ret_reg_data), .ret_mem_rd(ret_mem_rd), .ret_mem_wr(ret_mem_wr),
        .ret_mem_addr(ret_mem_addr), .ret_mem_data(ret_mem_data), .ret_halt(ret_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_inum(out_inum),
        .out_pc(out_pc), .out_reg(out_reg), .out_reg_data(out_reg_data), .out_mem_addr(out_mem_addr),
        .out_mem_data(out_mem_data), .cycle_count(cycle_count), .inst_count(inst_count),
        .overflow(overflow), .halted(halted), .done(done));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind; logic [CNT_W-1:0] inum; logic [ADDR_W-1:0] pc; logic [REG_W-1:0] rg;
        logic [DATA_W-1:0] rd; logic [ADDR_W-1:0] ma; logic [DATA_W-1:0] md;
    } rec_t;

    rec_t mq[$];
    logic [CNT_W-1:0] mInst = '0, mCycle = '0;
    logic mOvf = 1'b0;
    int mState = 0;  // 0 run, 1 drain, 2 done
    int checkCnt = 0, passCnt = 0, failCnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] kindOf(input logic h, input logic rw, input logic mr, input logic mw);
        if (h) return 3'd5;
        if (rw && mw) return 3'd3;
        if (rw && mr) return 3'd2;
        if (rw) return 3'd1;
        if (mw) return 3'd4;
        return 3'd0;
    endfunction

    // k: 0 nop, 1 reg, 2 load, 3 store-update, 4 store, 5 halt
    task automatic setEv(input logic v, input int k);
        ret_valid    = v;
        ret_pc       = 16'($urandom);
        ret_reg      = 3'($urandom);
        ret_reg_data = 16'($urandom);
        ret_mem_addr = 16'($urandom);
        ret_mem_data = 16'($urandom);
        ret_reg_wr   = (k == 1 || k == 2 || k == 3);
        ret_mem_rd   = (k == 2);
        ret_mem_wr   = (k == 3 || k == 4);
        ret_halt     = (k == 5);
    endtask

    task automatic checkAll();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_kind", 64'(out_kind), 64'(mq[0].kind));
            chk("out_inum", 64'(out_inum), 64'(mq[0].inum));
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("out_reg", 64'(out_reg), 64'(mq[0].rg));
            chk("out_reg_data", 64'(out_reg_data), 64'(mq[0].rd));
            chk("out_mem_addr", 64'(out_mem_addr), 64'(mq[0].ma));
            chk("out_mem_data", 64'(out_mem_data), 64'(mq[0].md));
        end
        chk("cycle_count", 64'(cycle_count), 64'(mCycle));
        chk("inst_count", 64'(inst_count), 64'(mInst));
        chk("overflow", 64'(overflow), 64'(mOvf));
        chk("halted", 64'(halted), 64'(mState != 0));
        chk("done", 64'(done), 64'(mState == 2));
    endtask

    // One clock: decide from pre-edge model state, advance the model, then compare.
    task automatic tick();
        int  sz = mq.size();
        logic pop = (sz != 0) && out_ready;
        logic acc = ret_valid && (mState == 0);
        int  st = mState;
        rec_t r;
        r.kind = kindOf(ret_halt, ret_reg_wr, ret_mem_rd, ret_mem_wr);
        r.inum = mInst; r.pc = ret_pc; r.rg = ret_reg; r.rd = ret_reg_data;
        r.ma = ret_mem_addr; r.md = ret_mem_data;
        @(posedge clk);
        if (rst) begin
            mq.delete(); mInst = '0; mCycle = '0; mOvf = 1'b0; mState = 0;
        end else begin
            if (st == 0) mCycle++;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (sz < DEPTH || pop) mq.push_back(r);
                else mOvf = 1'b1;
                mInst++;
                if (ret_halt) mState = 1;
            end
            if (st == 1 && sz == 0) mState = 2;
        end
        #1;
        checkAll();
    endtask

    task automatic doReset();
        rst = 1'b1; setEv(1'b0, 0); out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        // 1: reset values, then a single REG retire
        doReset();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_inst", 64'(inst_count), 64'(0));
        setEv(1'b1, 1); ret_pc = 16'h0000; ret_reg = 3'd3; ret_reg_data = 16'h1234; out_ready = 1'b1;
        tick();
        chk("t1_kind", 64'(out_kind), 64'(1));
        chk("t1_reg", 64'(out_reg), 64'(3));
        chk("t1_data", 64'(out_reg_data), 64'(16'h1234));
        chk("t1_inst", 64'(inst_count), 64'(1));
        setEv(1'b0, 0); tick();

        // 2: LD, bubble, ST
        doReset(); out_ready = 1'b1;
        setEv(1'b1, 2); tick();
        setEv(1'b0, 0); tick();
        setEv(1'b1, 4); tick();
        chk("t2_kind", 64'(out_kind), 64'(4));
        chk("t2_inum", 64'(out_inum), 64'(1));
        chk("t2_inst", 64'(inst_count), 64'(2));
        chk("t2_cycle", 64'(cycle_count), 64'(3));
        setEv(1'b0, 0); tick();

        // 3: overflow with stalled consumer, then drain
        doReset(); out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin setEv(1'b1, 1); tick(); end
        chk("t3_ovf", 64'(overflow), 64'(1));
        chk("t3_inst", 64'(inst_count), 64'(10));
        setEv(1'b0, 0); out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_inum", 64'(out_inum), 64'(i));
            tick();
        end
        chk("t3_empty", 64'(out_valid), 64'(0));

        // 4: full FIFO, push and pop together
        doReset(); out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin setEv(1'b1, 3); tick(); end
        out_ready = 1'b1; setEv(1'b1, 4); tick();
        chk("t4_ovf", 64'(overflow), 64'(0));
        setEv(1'b0, 0);
        for (int i = 0; i < DEPTH; i++) tick();
        chk("t4_inst", 64'(inst_count), 64'(DEPTH + 1));

        // 5: halt with 3 queued records
        doReset(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin setEv(1'b1, 1); tick(); end
        out_ready = 1'b1; setEv(1'b1, 5); ret_pc = 16'h0010; tick();
        chk("t5_halted", 64'(halted), 64'(1));
        n = 0;
        while (!done && n < 20) begin setEv(1'b1, 1); tick(); n++; end
        chk("t5_done", 64'(done), 64'(1));
        chk("t5_inst", 64'(inst_count), 64'(4));
        setEv(1'b1, 2); tick();

        // 6: reset during drain
        doReset(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin setEv(1'b1, 4); tick(); end
        setEv(1'b1, 5); tick();
        chk("t6_halted", 64'(halted), 64'(1));
        doReset();
        chk("t6_valid", 64'(out_valid), 64'(0));
        chk("t6_halted0", 64'(halted), 64'(0));
        setEv(1'b1, 1); tick();
        chk("t6_accept", 64'(inst_count), 64'(1));

        // random traffic
        doReset();
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 499) == 0) || (mState == 2 && $urandom_range(0, 9) == 0);
            setEv($urandom_range(0, 3) != 0, 0);
            ret_reg_wr   = 1'($urandom);
            ret_mem_rd   = 1'($urandom);
            ret_mem_wr   = 1'($urandom);
            ret_halt     = ($urandom_range(0, 149) == 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
